// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C target register block.
// FSM encoding, register-file size and bus acknowledge levels.
package iic_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } iic_state_t;

    localparam int REG_COUNT = 16;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/iic_in_filter.sv
// Two-flop synchronizer plus glitch filter for one I2C line.
// Flops preset to 1 so reset looks like an idle bus.
module iic_in_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = $clog2(FILT_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pad level into the CLK domain.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], din};
        end
    end

    // Accept a new level only after FILT_LEN identical samples.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            dout <= 1'b1;
            cnt  <= '0;
        end else if (sync[1] == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(FILT_LEN - 1)) begin
            dout <= sync[1];
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/iic_target_regs.sv
// I2C target exposing 16 byte registers with an auto-increment pointer.
// Fabric side gets a simple write port and a registered read port.
module iic_target_regs
    import iic_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       SCL,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    input  logic       LOC_WE,
    input  logic [3:0] LOC_ADDR,
    input  logic [7:0] LOC_WDATA,
    output logic [7:0] LOC_RDATA,
    output logic       WR_STROBE,
    output logic [3:0] WR_IDX,
    output logic       BUSY
);

    logic scl_f;
    logic sda_f;
    logic scl_d;
    logic sda_d;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    iic_state_t state;
    iic_state_t state_n;

    logic [7:0] shift;
    logic [2:0] bitcnt;
    logic [3:0] ptr;
    logic [7:0] regs [REG_COUNT];

    logic [7:0] byte_in;
    logic       last_bit;
    logic       addr_hit;
    logic       oe_n;
    logic       shift_en;
    logic       commit;
    logic       ptr_load;
    logic       rd_load;
    logic       busy_set;

    iic_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .din     (SCL),
        .dout    (scl_f)
    );

    iic_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .din     (SDA_IN),
        .dout    (sda_f)
    );

    // Previous filtered levels for edge and START/STOP detection.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

    assign byte_in  = {shift[6:0], sda_f};
    assign last_bit = (bitcnt == 3'd7);
    assign addr_hit = (byte_in[7:1] == DEV_ADDR);

    // Protocol state register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, per-bit actions and the SDA level for the next low phase.
    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        commit   = 1'b0;
        ptr_load = 1'b0;
        rd_load  = 1'b0;
        busy_set = 1'b0;

        unique case (state)
            ADDR_ACK, PTR_ACK, WDATA_ACK: oe_n = ~ACK;
            RDATA:                        oe_n = ~shift[7];
            default:                      oe_n = 1'b0;
        endcase

        if (start_det) begin
            state_n = ADDR;
        end else if (stop_det) begin
            state_n = IDLE;
        end else if (scl_rise) begin
            unique case (state)
                ADDR: begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        if (addr_hit) begin
                            state_n  = ADDR_ACK;
                            busy_set = 1'b1;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (shift[0]) begin
                        rd_load = 1'b1;
                        state_n = RDATA;
                    end else begin
                        state_n = PTR;
                    end
                end
                PTR: begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        ptr_load = 1'b1;
                        state_n  = PTR_ACK;
                    end
                end
                PTR_ACK: state_n = WDATA;
                WDATA: begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        commit  = 1'b1;
                        state_n = WDATA_ACK;
                    end
                end
                WDATA_ACK: state_n = WDATA;
                RDATA: begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        state_n = RDATA_ACK;
                    end
                end
                RDATA_ACK: begin
                    if (sda_f == NACK) begin
                        state_n = WAIT_STOP;
                    end else begin
                        rd_load = 1'b1;
                        state_n = RDATA;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    // Shifter, bit counter, pointer, SDA drive and status outputs.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            shift     <= 8'h00;
            bitcnt    <= 3'd0;
            ptr       <= 4'd0;
            SDA_OE    <= 1'b0;
            WR_STROBE <= 1'b0;
            WR_IDX    <= 4'd0;
            BUSY      <= 1'b0;
        end else begin
            WR_STROBE <= commit;
            if (commit) begin
                WR_IDX <= ptr;
            end
            if (start_det || stop_det) begin
                bitcnt <= 3'd0;
            end else if (shift_en) begin
                bitcnt <= bitcnt + 3'd1;
            end
            if (rd_load) begin
                shift <= regs[ptr];
            end else if (shift_en) begin
                shift <= byte_in;
            end
            if (ptr_load) begin
                ptr <= byte_in[3:0];
            end else if (commit || rd_load) begin
                ptr <= ptr + 4'd1;
            end
            if (scl_fall) begin
                SDA_OE <= oe_n;
            end
            if (stop_det) begin
                BUSY <= 1'b0;
            end else if (busy_set) begin
                BUSY <= 1'b1;
            end
        end
    end

    // Register file; the fabric write lands last so it wins a collision.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (commit) begin
                regs[ptr] <= byte_in;
            end
            if (LOC_WE) begin
                regs[LOC_ADDR] <= LOC_WDATA;
            end
        end
    end

    // Registered fabric read port.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            LOC_RDATA <= 8'h00;
        end else begin
            LOC_RDATA <= regs[LOC_ADDR];
        end
    end

endmodule

// File: tb/tb_iic_target_regs.sv
// Bench for iic_target_regs: bit-banged I2C master, fabric-port table,
// directed corner cases and random traffic against a byte-array model.
module tb_iic_target_regs;
    import iic_pkg::*;

    localparam int Q = 8;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } loc_vec_t;

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       SDA_OE;
    logic       LOC_WE = 1'b0;
    logic [3:0] LOC_ADDR = 4'd0;
    logic [7:0] LOC_WDATA = 8'h00;
    logic [7:0] LOC_RDATA;
    logic       WR_STROBE;
    logic [3:0] WR_IDX;
    logic       BUSY;

    int vecs = 0;
    int errs = 0;

    logic [7:0] mem [16];
    int strobe_log [512];
    int strobe_n = 0;
    int strobe_rd = 0;
    int oe_cnt = 0;
    int oe_hi_changes = 0;
    logic scl_prev = 1'b1;
    logic oe_prev = 1'b0;

    assign sda_bus = sda_m & ~SDA_OE;

    always #10 CLK = ~CLK;

    iic_target_regs dut (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .SCL       (scl_m),
        .SDA_IN    (sda_bus),
        .SDA_OE    (SDA_OE),
        .LOC_WE    (LOC_WE),
        .LOC_ADDR  (LOC_ADDR),
        .LOC_WDATA (LOC_WDATA),
        .LOC_RDATA (LOC_RDATA),
        .WR_STROBE (WR_STROBE),
        .WR_IDX    (WR_IDX),
        .BUSY      (BUSY)
    );

    always @(negedge CLK) begin
        if (WR_STROBE && strobe_n < 512) begin
            strobe_log[strobe_n] = int'(WR_IDX);
            strobe_n++;
        end
        if (SDA_OE) oe_cnt++;
        if (scl_m && scl_prev && (SDA_OE != oe_prev)) oe_hi_changes++;
        scl_prev = scl_m;
        oe_prev = SDA_OE;
    end

    initial begin
        #(150000 * 20);
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic q();
        repeat (Q) @(posedge CLK);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q(); q();
    endtask

    task automatic bit_w(input logic b, input bit glitch);
        sda_m = b; q();
        if (glitch) begin
            scl_m = 1'b1;
            @(posedge CLK); #1;
            scl_m = 1'b0;
            q();
        end
        scl_m = 1'b1; q(); q();
        scl_m = 1'b0; q();
    endtask

    task automatic bit_r(output logic b);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        b = sda_bus; q();
        scl_m = 1'b0; q();
    endtask

    task automatic byte_w(input logic [7:0] b, output logic ack,
                          input int glitch_bit);
        for (int i = 7; i >= 0; i--) bit_w(b[i], i == glitch_bit);
        bit_r(ack);
    endtask

    task automatic byte_r(output logic [7:0] d, input logic ack_bit);
        for (int i = 7; i >= 0; i--) bit_r(d[i]);
        bit_w(ack_bit, 1'b0);
    endtask

    task automatic wr_ack(input logic [7:0] b, input string nm);
        logic a;
        byte_w(b, a, -1);
        chk(nm, a, ACK);
    endtask

    task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
        LOC_ADDR = a;
        repeat (2) @(posedge CLK);
        #1;
        d = LOC_RDATA;
    endtask

    task automatic check_reg(input int a, input string nm);
        logic [7:0] d;
        loc_read(4'(a), d);
        chk(nm, d, mem[a]);
    endtask

    task automatic check_all_regs(input string nm);
        for (int i = 0; i < 16; i++) check_reg(i, nm);
    endtask

    task automatic expect_strobes(input int n, input int first,
                                  input string nm);
        chk({nm, "_count"}, strobe_n - strobe_rd, n);
        for (int i = 0; i < n; i++) begin
            if (strobe_rd + i < strobe_n)
                chk({nm, "_idx"}, strobe_log[strobe_rd + i],
                    (first + i) % 16);
        end
        strobe_rd = strobe_n;
    endtask

    initial begin
        loc_vec_t tbl [8];
        logic [7:0] d;
        logic a;
        int oe0;
        int t;
        int p;
        int n;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_sda_oe", SDA_OE, 0);
        chk("rst_wr_strobe", WR_STROBE, 0);
        chk("rst_wr_idx", WR_IDX, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_loc_rdata", LOC_RDATA, 0);
        RESET_n = 1'b1;
        q();

        tbl[0] = '{1'b1, 4'd2,  8'h5A, 8'h5A};
        tbl[1] = '{1'b0, 4'd3,  8'h00, 8'h00};
        tbl[2] = '{1'b1, 4'd15, 8'hFF, 8'hFF};
        tbl[3] = '{1'b0, 4'd2,  8'h00, 8'h5A};
        tbl[4] = '{1'b1, 4'd2,  8'h00, 8'h00};
        tbl[5] = '{1'b0, 4'd15, 8'h00, 8'hFF};
        tbl[6] = '{1'b1, 4'd0,  8'h81, 8'h81};
        tbl[7] = '{1'b0, 4'd1,  8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            LOC_WE = tbl[i].we;
            LOC_ADDR = tbl[i].addr;
            LOC_WDATA = tbl[i].wdata;
            @(posedge CLK); #1;
            LOC_WE = 1'b0;
            if (tbl[i].we) mem[tbl[i].addr] = tbl[i].wdata;
            repeat (2) @(posedge CLK);
            #1;
            chk("loc_table", LOC_RDATA, tbl[i].exp);
        end

        bus_start();
        wr_ack(8'hA0, "w1_addr_ack");
        chk("w1_busy_set", BUSY, 1);
        wr_ack(8'h03, "w1_ptr_ack");
        wr_ack(8'h5A, "w1_d0_ack");
        wr_ack(8'hC3, "w1_d1_ack");
        bus_stop();
        chk("w1_busy_clr", BUSY, 0);
        mem[3] = 8'h5A;
        mem[4] = 8'hC3;
        expect_strobes(2, 3, "w1_strobe");
        check_reg(3, "w1_reg3");
        check_reg(4, "w1_reg4");

        bus_start();
        wr_ack(8'hA0, "w2_addr_ack");
        wr_ack(8'h0F, "w2_ptr_ack");
        wr_ack(8'h11, "w2_d0_ack");
        wr_ack(8'h22, "w2_d1_ack");
        bus_stop();
        mem[15] = 8'h11;
        mem[0] = 8'h22;
        expect_strobes(2, 15, "w2_strobe");
        check_reg(15, "w2_reg15");
        check_reg(0, "w2_reg0_wrap");

        bus_start();
        wr_ack(8'hA0, "r1_addr_ack");
        wr_ack(8'h03, "r1_ptr_ack");
        bus_start();
        wr_ack(8'hA1, "r1_raddr_ack");
        byte_r(d, ACK);
        chk("r1_byte0", d, 8'h5A);
        byte_r(d, NACK);
        chk("r1_byte1", d, 8'hC3);
        chk("r1_wait_stop", int'(dut.state), int'(WAIT_STOP));
        chk("r1_busy_held", BUSY, 1);
        bus_stop();
        chk("r1_idle", int'(dut.state), int'(IDLE));
        chk("r1_busy_clr", BUSY, 0);
        expect_strobes(0, 0, "r1_strobe");

        oe0 = oe_cnt;
        bus_start();
        byte_w(8'hA2, a, -1);
        chk("nm_nack", a, NACK);
        chk("nm_oe_quiet", oe_cnt - oe0, 0);
        chk("nm_busy", BUSY, 0);
        byte_w(8'h03, a, -1);
        byte_w(8'h99, a, -1);
        bus_stop();
        chk("nm_oe_quiet_all", oe_cnt - oe0, 0);
        expect_strobes(0, 0, "nm_strobe");
        check_all_regs("nm_regs");

        bus_start();
        wr_ack(8'hA0, "gl_addr_ack");
        wr_ack(8'h07, "gl_ptr_ack");
        byte_w(8'h96, a, 3);
        chk("gl_d0_ack", a, ACK);
        byte_w(8'h69, a, 6);
        chk("gl_d1_ack", a, ACK);
        bus_stop();
        mem[7] = 8'h96;
        mem[8] = 8'h69;
        expect_strobes(2, 7, "gl_strobe");
        check_reg(7, "gl_reg7");
        check_reg(8, "gl_reg8");

        bus_start();
        wr_ack(8'hA0, "co_addr_ack");
        wr_ack(8'h06, "co_ptr_ack");
        d = 8'h3C;
        for (int i = 7; i >= 1; i--) bit_w(d[i], 1'b0);
        sda_m = d[0]; q();
        LOC_ADDR = 4'd6;
        LOC_WDATA = 8'h77;
        LOC_WE = 1'b1;
        scl_m = 1'b1;
        t = 0;
        while (!WR_STROBE && t < 64) begin
            @(posedge CLK); #1;
            t++;
        end
        LOC_WE = 1'b0;
        chk("co_strobe_seen", WR_STROBE, 1);
        q(); q();
        scl_m = 1'b0; q();
        bit_r(a);
        chk("co_d_ack", a, ACK);
        bus_stop();
        mem[6] = 8'h77;
        expect_strobes(1, 6, "co_strobe");
        check_reg(6, "co_loc_wins");

        bus_start();
        wr_ack(8'hA0, "rs_addr_ack");
        wr_ack(8'h01, "rs_ptr_ack");
        for (int i = 0; i < 4; i++) bit_w(1'b1, 1'b0);
        sda_m = 1'b1;
        RESET_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        chk("rs_busy", BUSY, 0);
        chk("rs_sda_oe", SDA_OE, 0);
        RESET_n = 1'b1;
        q();
        for (int i = 0; i < 4; i++) bit_w(1'b0, 1'b0);
        bit_r(a);
        chk("rs_ignored", a, NACK);
        bus_stop();
        expect_strobes(0, 0, "rs_strobe");
        check_all_regs("rs_regs_zero");
        bus_start();
        wr_ack(8'hA0, "rs2_addr_ack");
        wr_ack(8'h0A, "rs2_ptr_ack");
        wr_ack(8'hE7, "rs2_d_ack");
        bus_stop();
        mem[10] = 8'hE7;
        expect_strobes(1, 10, "rs2_strobe");
        check_reg(10, "rs2_reg10");

        for (int k = 0; k < 3; k++) begin
            p = int'($urandom_range(0, 15));
            n = int'($urandom_range(1, 4));
            bus_start();
            wr_ack(8'hA0, "rw_addr_ack");
            d = {4'($urandom), 4'(p)};
            wr_ack(d, "rw_ptr_ack");
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                wr_ack(d, "rw_data_ack");
                mem[(p + i) % 16] = d;
            end
            bus_stop();
            expect_strobes(n, p, "rw_strobe");
        end

        for (int k = 0; k < 3; k++) begin
            p = int'($urandom_range(0, 15));
            n = int'($urandom_range(1, 4));
            bus_start();
            wr_ack(8'hA0, "rr_addr_ack");
            d = {4'($urandom), 4'(p)};
            wr_ack(d, "rr_ptr_ack");
            bus_start();
            wr_ack(8'hA1, "rr_raddr_ack");
            for (int i = 0; i < n; i++) begin
                byte_r(d, (i == n - 1) ? NACK : ACK);
                chk("rr_data", d, mem[(p + i) % 16]);
            end
            bus_stop();
            expect_strobes(0, 0, "rr_strobe");
        end

        check_all_regs("final_regs");
        chk("oe_stable_scl_high", oe_hi_changes, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/iic_target_regs.md
IIC_TARGET_REGS -- requirements
Module: iic_target_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50: 7-bit I2C target address this block answers to.
REQ-002 SHALL have parameter FILT_LEN, default 3: number of consecutive equal samples required to accept a new SCL/SDA level.
REQ-003 SHALL have port CLK input 1: single system clock (50 MHz); all logic on its rising edge.
REQ-004 SHALL have port RESET_n input 1: asynchronous, active-low reset.
REQ-005 SHALL have port SCL input 1: I2C clock from the bus (asynchronous to CLK).
REQ-006 SHALL have port SDA_IN input 1: I2C data as read from the pad (asynchronous to CLK).
REQ-007 SHALL have port SDA_OE output 1: when 1, the pad drives SDA low; when 0, the pad releases SDA (open drain).
REQ-008 SHALL have port LOC_WE input 1: fabric-side register write enable.
REQ-009 SHALL have port LOC_ADDR input 4: fabric-side register index.
REQ-010 SHALL have port LOC_WDATA input 8: fabric-side write data.
REQ-011 SHALL have port LOC_RDATA output 8: register contents at LOC_ADDR, registered with 1-cycle latency.
REQ-012 SHALL have port WR_STROBE output 1: one-cycle pulse when an I2C write commits a register.
REQ-013 SHALL have port WR_IDX output 4: index of the register committed on the last WR_STROBE.
REQ-014 SHALL have port BUSY output 1: high from an addressed START (address match) until the next STOP.

Function
REQ-015 SHALL synchronize SCL/SDA_IN through 2 flops, then filter: a filtered level changes only after FILT_LEN identical synchronized samples.
REQ-016 SHALL detect START as filtered SDA falling while filtered SCL is high, and STOP as filtered SDA rising while filtered SCL is high; both take priority over bit processing in the same cycle.
REQ-017 SHALL sample data bits on filtered SCL rising and update SDA_OE on the cycle after filtered SCL falling; SDA_OE never changes while filtered SCL is high.
REQ-018 SHALL implement FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-019 SHALL go from any state to ADDR on START (including repeated START), and from any state to IDLE on STOP; the bit counter SHALL clear on both.
REQ-020 ADDR: shift 8 bits MSB first; if bits[7:1]==DEV_ADDR, go to ADDR_ACK and drive ACK (SDA_OE=1) for the 9th clock; otherwise go to WAIT_STOP with SDA_OE=0.
REQ-021 After ADDR_ACK: if R/W=0, go to PTR; if R/W=1, load the shift register with reg[ptr], increment ptr, and go to RDATA.
REQ-022 PTR: the received byte's low 4 bits SHALL set ptr (upper 4 bits ignored); ACK; then go to WDATA.
REQ-023 WDATA: the received byte SHALL be written to reg[ptr] at the 8th SCL rising; WR_STROBE SHALL pulse with WR_IDX=ptr; ptr SHALL increment; ACK; WDATA repeats.
REQ-024 RDATA: SDA_OE SHALL equal the inverse of the current shift bit for 8 bits; in RDATA_ACK SDA_OE=0 and the master's bit is sampled: ACK(0) reloads the shift register from reg[ptr], increments ptr, and returns to RDATA; NACK(1) goes to WAIT_STOP.
REQ-025 ptr SHALL wrap 15 -> 0 for both reads and writes.
REQ-026 If an I2C commit and LOC_WE target the same register in the same cycle, the LOC_WE value SHALL be stored; WR_STROBE SHALL still pulse.
REQ-027 SHALL never stretch SCL.

Reset
REQ-028 On RESET_n low: state=IDLE, all 16 registers=8'h00, ptr=0, SDA_OE=0, WR_STROBE=0, WR_IDX=0, BUSY=0, LOC_RDATA=8'h00; the filter and synchronizer flops SHALL preset to 1 (bus idle).
REQ-029 After reset is released mid-transfer, the block SHALL ignore the bus until the next START.

Structure
REQ-030 A shared package iic_pkg SHALL hold the FSM state enum, the register-count constant (16), and the ACK/NACK constants.
REQ-031 The synchronizer and glitch filter SHALL be one sub-module, iic_in_filter, instantiated once each for SCL and SDA_IN.

Verification
REQ-032 Write 0xA0, 0x03, 0x5A, 0xC3, STOP -> ACK on all 4 bytes; reg3=0x5A, reg4=0xC3; two WR_STROBE pulses with WR_IDX 3 then 4.
REQ-033 Write 0xA0, 0x0F, 0x11, 0x22 -> reg15=0x11, reg0=0x22 (pointer wraps).
REQ-034 Write 0xA0, 0x03, repeated START, 0xA1, read 2 bytes (master ACK, then NACK), STOP -> SDA returns 0x5A then 0xC3; then WAIT_STOP, then IDLE.
REQ-035 Address 0xA2 (no match) -> SDA_OE stays 0 through the 9th clock; BUSY stays 0; no register changes.
REQ-036 1-cycle SCL glitch during a data bit with FILT_LEN=3 -> no extra bit counted; the byte is received correctly.
REQ-037 RESET_n pulsed low during WDATA -> all registers read 0x00 via LOC_RDATA; the next full write transaction succeeds.
